feature_burst_fetch: RTL and testbench

Parametrised burst-mode successor to the single-beat input feature fetch. On one start command it reads burst_len consecutive words from external feature memory over a request/grant/valid interface. It keeps up to MAX_OUTSTANDING reads in flight and writes the returned words into one of NUM_BANKS on-chip feature buffers at consecutive addresses. It pulses fetch_done to the top FSM only after every requested beat has been written.

---
 rtl/feature_burst_fetch.sv | 152 +++++++++++++++
 tb/tb_feature_burst_fetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_burst_fetch.sv
// Burst feature fetch: reads burst_len consecutive words from external memory,
// keeps up to MAX_OUTSTANDING reads in flight, and writes the returns into one on-chip bank.
module feature_burst_fetch #(
   parameter  int DATA_W          = 128,
   parameter  int SRC_AW          = 16,
   parameter  int DST_AW          = 15,
   parameter  int LEN_W           = 8,
   parameter  int NUM_BANKS       = 2,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int BS_W            = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [SRC_AW-1:0]    src_addr,
   input  logic [DST_AW-1:0]    dst_addr,
   input  logic [LEN_W-1:0]     burst_len,
   input  logic [BS_W-1:0]      bank_sel,
   output logic                 busy,
   output logic                 mem_rd_req,
   output logic [SRC_AW-1:0]    mem_rd_addr,
   input  logic                 mem_rd_gnt,
   input  logic                 mem_rd_valid,
   input  logic [DATA_W-1:0]    mem_rd_data,
   output logic                 wr_en,
   output logic [DST_AW-1:0]    wr_addr,
   output logic [DATA_W-1:0]    wr_data,
   output logic [NUM_BANKS-1:0] wr_bank,
   output logic                 fetch_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                r_state;
   logic [SRC_AW-1:0]     r_src;
   logic [DST_AW-1:0]     r_dst;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_issued;
   logic [LEN_W-1:0]      r_returned;
   logic [OUT_W-1:0]      r_out;
   logic                  r_busy;
   logic                  r_req;
   logic [SRC_AW-1:0]     r_rd_addr;
   logic                  r_wr_en;
   logic [DST_AW-1:0]     r_wr_addr;
   logic [DATA_W-1:0]     r_wr_data;
   logic [NUM_BANKS-1:0]  r_wr_bank;
   logic                  r_done;

   logic                  w_fire;
   logic                  w_ret;
   logic [LEN_W-1:0]      w_issued_n;
   logic [OUT_W-1:0]      w_out_n;
   logic [NUM_BANKS-1:0]  w_bank_oh;

   always_comb begin
      w_fire     = r_req & mem_rd_gnt;
      // returns beyond the burst length, or outside a burst, are dropped
      w_ret      = mem_rd_valid & ((r_state == ISSUE) | (r_state == DRAIN)) & (r_returned != r_len);
      w_issued_n = r_issued + LEN_W'(w_fire);
      w_out_n    = r_out + OUT_W'(w_fire) - OUT_W'(w_ret);
      w_bank_oh  = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         w_bank_oh[b] = (bank_sel == BS_W'(b));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_src      <= '0;
         r_dst      <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_returned <= '0;
         r_out      <= '0;
         r_busy     <= 1'b0;
         r_req      <= 1'b0;
         r_rd_addr  <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_bank  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_wr_en <= w_ret;
         if (w_ret) begin
            r_wr_data  <= mem_rd_data;
            r_wr_addr  <= r_dst + DST_AW'(r_returned);
            r_returned <= r_returned + 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_src      <= src_addr;
                  r_dst      <= dst_addr;
                  r_len      <= burst_len;
                  r_issued   <= '0;
                  r_returned <= '0;
                  r_out      <= '0;
                  r_busy     <= 1'b1;
                  r_wr_bank  <= w_bank_oh;
                  r_rd_addr  <= src_addr;
                  if (burst_len == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ISSUE;
                     r_req   <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               r_issued <= w_issued_n;
               r_out    <= w_out_n;
               // request is recomputed from next-cycle counts, so it holds steady while ungranted
               if (w_issued_n == r_len) begin
                  r_state <= DRAIN;
                  r_req   <= 1'b0;
               end else begin
                  r_req     <= (w_out_n < OUT_W'(MAX_OUTSTANDING));
                  r_rd_addr <= r_src + SRC_AW'(w_issued_n);
               end
            end
            DRAIN: begin
               r_out <= w_out_n;
               if (r_returned == r_len) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign mem_rd_req  = r_req;
   assign mem_rd_addr = r_rd_addr;
   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign wr_bank     = r_wr_bank;
   assign fetch_done  = r_done;

endmodule

// File: tb/tb_feature_burst_fetch.sv
// Scoreboard bench for feature_burst_fetch: a memory model answers reads, monitors
// pop expected reads/writes/done pulses from queues filled by the stimulus.
module tb_feature_burst_fetch;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [15:0]  src_addr;
   logic [14:0]  dst_addr;
   logic [7:0]   burst_len;
   logic [0:0]   bank_sel;
   logic         busy;
   logic         mem_rd_req;
   logic [15:0]  mem_rd_addr;
   logic         mem_rd_gnt;
   logic         mem_rd_valid;
   logic [127:0] mem_rd_data;
   logic         wr_en;
   logic [14:0]  wr_addr;
   logic [127:0] wr_data;
   logic [1:0]   wr_bank;
   logic         fetch_done;

   feature_burst_fetch #(
      .DATA_W(128), .SRC_AW(16), .DST_AW(15), .LEN_W(8), .NUM_BANKS(2), .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .burst_len(burst_len), .bank_sel(bank_sel), .busy(busy),
      .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
      .fetch_done(fetch_done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [14:0] a; logic [127:0] d; logic [1:0] b; } wr_t;
   typedef struct { int t; logic [127:0] d; } pend_t;

   wr_t          exp_wr[$];
   logic [15:0]  exp_rd[$];
   pend_t        pend[$];
   int           exp_done   = 0;
   int           checks     = 0;
   int           errors     = 0;
   int           pcyc       = 0;
   int           lat        = 2;
   int           fires      = 0;
   int           done_cnt   = 0;
   int           done_cyc   = 0;
   int           wr_seen    = 0;
   int           wr_first   = 0;
   int           wr_last    = 0;
   logic         prev_hold  = 1'b0;
   logic [15:0]  prev_addr  = '0;
   logic [15:0]  wrap_rd[4];
   logic [14:0]  wrap_wr[4];

   function automatic logic [127:0] mkdata(input logic [15:0] a);
      return {a, ~a, a ^ 16'h1234, a + 16'd7, {a[7:0], a[15:8]}, ~a ^ 16'h00FF, a, 16'hC0DE};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic chk_le(input string nm, input int act, input int lim);
      checks++;
      if (act > lim) begin
         errors++;
         $display("FAIL %s actual=%0d required<=%0d", nm, act, lim);
      end
   endtask

   task automatic push_exp(input logic [15:0] ra, input logic [14:0] wa, input logic [1:0] bk);
      wr_t e;
      e.a = wa;
      e.d = mkdata(ra);
      e.b = bk;
      exp_rd.push_back(ra);
      exp_wr.push_back(e);
   endtask

   task automatic start_cmd(input logic [15:0] s, input logic [14:0] d, input logic [7:0] l,
                            input logic b);
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; burst_len = l; bank_sel = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int n);
      int d0;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL done_timeout actual=no_done required=done_within_%0d", bound);
      end
   endtask

   task automatic wait_fires(input int target, input int bound);
      int n;
      n = 0;
      while (fires < target && n < bound) begin
         @(posedge clk);
         n++;
      end
      chk_le("fire_timeout", target - fires, 0);
   endtask

   task automatic chk_idle_zero(input string nm);
      chk({nm, "_ctrl"}, {busy, mem_rd_req, wr_en, fetch_done}, 4'b0000);
      chk({nm, "_addr"}, {mem_rd_addr, wr_addr, wr_bank}, '0);
      chk({nm, "_data"}, wr_data, '0);
   endtask

   always @(posedge clk) pcyc <= pcyc + 1;

   // memory model plus read-side monitor
   always @(negedge clk) begin
      if (pend.size() > 0 && pend[0].t <= pcyc) begin
         mem_rd_valid = 1'b1;
         mem_rd_data  = pend[0].d;
         void'(pend.pop_front());
      end else begin
         mem_rd_valid = 1'b0;
      end
      if (prev_hold) begin
         chk("req_hold", {mem_rd_req, mem_rd_addr}, {1'b1, prev_addr});
      end
      if (mem_rd_req && mem_rd_gnt && !rst) begin
         pend_t p;
         fires++;
         if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected actual=%0h required=none", mem_rd_addr);
         end else begin
            chk("rd_addr", mem_rd_addr, exp_rd.pop_front());
         end
         p.t = pcyc + lat;
         p.d = mkdata(mem_rd_addr);
         pend.push_back(p);
         chk_le("outstanding", pend.size(), 4);
      end
      prev_hold = mem_rd_req && !mem_rd_gnt && !rst;
      prev_addr = mem_rd_addr;
   end

   // write-side monitor
   always @(negedge clk) begin
      if (wr_en) begin
         wr_seen++;
         if (wr_seen == 1) wr_first = pcyc;
         wr_last = pcyc;
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected actual=%0h required=none", wr_addr);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", wr_addr, e.a);
            chk("wr_data", wr_data, e.d);
            chk("wr_bank", wr_bank, e.b);
         end
      end
   end

   // completion monitor
   always @(negedge clk) begin
      if (fetch_done) begin
         done_cnt++;
         done_cyc = pcyc;
         checks++;
         if (exp_done == 0 || exp_wr.size() != 0 || !busy) begin
            errors++;
            $display("FAIL done_pulse actual=pending_wr%0d_busy%0b required=expected_done%0d_pending0_busy1",
                     exp_wr.size(), busy, exp_done);
         end
         if (exp_done > 0) exp_done--;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int d0;
      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; burst_len = '0; bank_sel = '0;
      mem_rd_gnt = 1'b1; mem_rd_valid = 1'b0; mem_rd_data = '0;
      wrap_rd = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
      wrap_wr = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      repeat (3) @(posedge clk);
      #1;
      chk_idle_zero("reset");
      rst = 1'b0;

      // single beat to bank 1
      lat = 2; wr_seen = 0;
      push_exp(16'h0010, 15'h0005, 2'b10);
      exp_done = 1;
      start_cmd(16'h0010, 15'h0005, 8'd1, 1'b1);
      wait_done(30, n);
      #1;
      chk("single_busy_after", busy, 1'b0);
      chk("single_done_after_wr", done_cyc, wr_last + 1);
      chk("single_wr_count", wr_seen, 1);

      // streaming burst, one beat per cycle
      lat = 3; wr_seen = 0;
      for (int i = 0; i < 8; i++) push_exp(16'h0100 + 16'(i), 15'h0020 + 15'(i), 2'b01);
      exp_done = 1;
      start_cmd(16'h0100, 15'h0020, 8'd8, 1'b0);
      wait_done(60, n);
      chk_le("stream_latency", n, 14);
      chk("stream_wr_count", wr_seen, 8);
      chk("stream_wr_span", wr_last - wr_first, 7);

      // grant withheld mid-burst
      lat = 2; wr_seen = 0; d0 = fires;
      for (int i = 0; i < 8; i++) push_exp(16'h0200 + 16'(i), 15'h0040 + 15'(i), 2'b10);
      exp_done = 1;
      start_cmd(16'h0200, 15'h0040, 8'd8, 1'b1);
      wait_fires(d0 + 3, 40);
      @(posedge clk); #1 mem_rd_gnt = 1'b0;
      repeat (5) @(posedge clk);
      #1 mem_rd_gnt = 1'b1;
      wait_done(80, n);
      chk("bp_wr_count", wr_seen, 8);

      // zero length
      wr_seen = 0; d0 = fires;
      exp_done = 1;
      start_cmd(16'h1234, 15'h0777, 8'd0, 1'b0);
      wait_done(10, n);
      chk_le("zero_latency", n, 2);
      #1;
      chk("zero_busy_after", busy, 1'b0);
      chk("zero_no_traffic", {fires - d0, wr_seen}, 0);

      // address wrap on both sides
      lat = 1; wr_seen = 0;
      for (int i = 0; i < 4; i++) push_exp(wrap_rd[i], wrap_wr[i], 2'b01);
      exp_done = 1;
      start_cmd(16'hFFFF, 15'h7FFE, 8'd4, 1'b0);
      wait_done(40, n);
      chk("wrap_wr_count", wr_seen, 4);

      // start during a burst is ignored
      lat = 3; wr_seen = 0; d0 = fires;
      for (int i = 0; i < 6; i++) push_exp(16'h0500 + 16'(i), 15'h0300 + 15'(i), 2'b10);
      exp_done = 1;
      start_cmd(16'h0500, 15'h0300, 8'd6, 1'b1);
      wait_fires(d0 + 2, 40);
      @(posedge clk); #1;
      src_addr = 16'h0AAA; dst_addr = 15'h0BBB; burst_len = 8'd2; bank_sel = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      d0 = done_cnt;
      wait_done(60, n);
      repeat (10) @(posedge clk);
      chk("ign_done_count", done_cnt - d0, 1);
      chk("ign_wr_count", wr_seen, 6);

      // reset in the middle of a burst, stray returns afterwards
      lat = 4; wr_seen = 0;
      for (int i = 0; i < 8; i++) push_exp(16'h0300 + 16'(i), 15'h0100 + 15'(i), 2'b10);
      exp_done = 1;
      start_cmd(16'h0300, 15'h0100, 8'd8, 1'b1);
      n = 0;
      while (wr_seen < 3 && n < 60) begin
         @(posedge clk);
         n++;
      end
      chk_le("rst_wait_timeout", 3 - wr_seen, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      exp_wr.delete(); exp_rd.delete(); exp_done = 0;
      @(posedge clk); #1;
      chk_idle_zero("midrst");
      rst = 1'b0; wr_seen = 0; d0 = done_cnt;
      repeat (15) @(posedge clk);
      #1;
      chk("midrst_quiet", {wr_seen, done_cnt - d0, 31'(busy)}, 0);

      lat = 2;
      for (int i = 0; i < 3; i++) push_exp(16'h0400 + 16'(i), 15'h0200 + 15'(i), 2'b01);
      exp_done = 1;
      start_cmd(16'h0400, 15'h0200, 8'd3, 1'b0);
      wait_done(40, n);
      chk("post_rst_wr_count", wr_seen, 3);

      repeat (3) @(posedge clk);
      chk("queues_empty", {32'(exp_wr.size()), 32'(exp_rd.size()), 32'(exp_done)}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
